// File: rtl/bcd_parity_monitor.sv
// Resynchronises and deglitches a ripple-counter BCD digit, commits stable legal digits
// and keeps even/odd tallies. Optional 7-segment output enabled by defining SEG7_EN.
module bcd_parity_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       bcd_in,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             clr_err,
    output logic [3:0]       digit,
    output logic             digit_vld,
    output logic             is_even,
    output logic             is_odd,
    output logic             rollover,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt,
    output logic             illegal,
    output logic             err_sticky,
    output logic [1:0]       dbg_state
`ifdef SEG7_EN
    ,
    output logic [6:0]       seg_n
`endif
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       cand_q, cand_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [3:0]       digit_q, digit_d;
    logic             have_q, have_d;
    logic             vld_q, roll_q, roll_d, ill_q, err_q, err_d;
    logic [CNT_W-1:0] even_q, even_d, odd_q, odd_d;
    logic             restart, ready, commit, illegal_evt;

    // Stability filter: restart on any change of the synced code, otherwise count up.
    always_comb begin
        cand_d  = cand_q;
        stab_d  = stab_q;
        restart = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            stab_d  = SW'(1);
            restart = 1'b1;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SW'(1);
        end
    end

    // The >= keeps a legal candidate commit-ready while en is held low.
    assign ready = (sync2_q == cand_q) && (stab_q >= STAB_LAST);

    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        illegal_evt = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (restart) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (ready) begin
                    if (cand_q > 4'd9) begin
                        illegal_evt = 1'b1;
                        state_d     = have_q ? S_HOLD : S_EMPTY;
                    end else if (have_q && cand_q == digit_q) begin
                        state_d = S_HOLD;
                    end else if (en) begin
                        commit  = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (restart) state_d = S_SETTLE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        digit_d = digit_q;
        have_d  = have_q;
        roll_d  = 1'b0;
        even_d  = even_q;
        odd_d   = odd_q;
        if (commit) begin
            digit_d = cand_q;
            have_d  = 1'b1;
            roll_d  = have_q && (digit_q == 4'd9) && (cand_q == 4'd0);
            if (cand_q[0]) begin
                if (!(&odd_q)) odd_d = odd_q + CNT_W'(1);
            end else begin
                if (!(&even_q)) even_d = even_q + CNT_W'(1);
            end
        end
        if (clr_cnt) begin
            even_d = '0;
            odd_d  = '0;
        end
        err_d = err_q;
        if (illegal_evt)  err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            digit_q <= '0;
            have_q  <= 1'b0;
            vld_q   <= 1'b0;
            roll_q  <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
            even_q  <= '0;
            odd_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= bcd_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            digit_q <= digit_d;
            have_q  <= have_d;
            vld_q   <= commit;
            roll_q  <= roll_d;
            ill_q   <= illegal_evt;
            err_q   <= err_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
        end
    end

    assign digit      = digit_q;
    assign digit_vld  = vld_q;
    assign is_even    = have_q && !digit_q[0];
    assign is_odd     = have_q && digit_q[0];
    assign rollover   = roll_q;
    assign even_cnt   = even_q;
    assign odd_cnt    = odd_q;
    assign illegal    = ill_q;
    assign err_sticky = err_q;
    assign dbg_state  = state_q;

`ifdef SEG7_EN
    // Active-low {g,f,e,d,c,b,a}; blank until the first commit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0:    on = 7'h3F;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5B;
            4'd3:    on = 7'h4F;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6D;
            4'd6:    on = 7'h7D;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7F;
            4'd9:    on = 7'h6F;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    logic [6:0] seg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         seg_q <= 7'h7F;
        else if (commit) seg_q <= seg_decode(cand_q);
    end

    assign seg_n = seg_q;
`endif

endmodule

// File: tb/tb_bcd_parity_monitor.sv
// Directed bench for bcd_parity_monitor: reset, sweep, glitch, illegal, enable/clear, saturation.
module tb_bcd_parity_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd_in = 4'd0;
    logic       en = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       clr_err = 1'b0;

    logic [3:0] digit;
    logic       digit_vld, is_even, is_odd, rollover, illegal, err_sticky;
    logic [7:0] even_cnt, odd_cnt;
    logic [1:0] dbg_state;

    logic [3:0] s_digit;
    logic       s_vld, s_even, s_odd, s_roll, s_ill, s_err;
    logic [1:0] s_even_cnt, s_odd_cnt, s_state;
`ifdef SEG7_EN
    logic [6:0] seg_n, s_seg_n;
`endif

    int n_checks = 0;
    int n_bad    = 0;
    int vld_total = 0, roll_total = 0, ill_total = 0;
    int vld0, roll0, ill0, even0, odd0;

    always #5 clk = ~clk;

    bcd_parity_monitor #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .en(en), .clr_cnt(clr_cnt), .clr_err(clr_err),
        .digit(digit), .digit_vld(digit_vld), .is_even(is_even), .is_odd(is_odd),
        .rollover(rollover), .even_cnt(even_cnt), .odd_cnt(odd_cnt), .illegal(illegal),
        .err_sticky(err_sticky), .dbg_state(dbg_state)
`ifdef SEG7_EN
        , .seg_n(seg_n)
`endif
    );

    bcd_parity_monitor #(.STABLE_CYCLES(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .en(en), .clr_cnt(clr_cnt), .clr_err(clr_err),
        .digit(s_digit), .digit_vld(s_vld), .is_even(s_even), .is_odd(s_odd),
        .rollover(s_roll), .even_cnt(s_even_cnt), .odd_cnt(s_odd_cnt), .illegal(s_ill),
        .err_sticky(s_err), .dbg_state(s_state)
`ifdef SEG7_EN
        , .seg_n(s_seg_n)
`endif
    );

    // Pulse counters sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (digit_vld === 1'b1) vld_total++;
        if (rollover === 1'b1)  roll_total++;
        if (illegal === 1'b1)   ill_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        bcd_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        vld0  = vld_total;
        roll0 = roll_total;
        ill0  = ill_total;
        even0 = int'(even_cnt);
        odd0  = int'(odd_cnt);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_is_even", 32'(is_even), 32'd0);
        check("rst_is_odd", 32'(is_odd), 32'd0);
        check("rst_even_cnt", 32'(even_cnt), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
`ifdef SEG7_EN
        check("rst_seg", 32'(seg_n), 32'h7F);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 1: reset asserted while a candidate is settling
        hold(4'd5, 3);
        check("t1_settling", 32'(dbg_state), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_state", 32'(dbg_state), 32'd0);
        check("t1_rst_vld", 32'(digit_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        snap();
        hold(4'd5, 10);
        check("t1_digit", 32'(digit), 32'd5);
        check("t1_vld_pulses", 32'(vld_total - vld0), 32'd1);
        check("t1_is_odd", 32'(is_odd), 32'd1);
        check("t1_is_even", 32'(is_even), 32'd0);
        check("t1_odd_cnt", 32'(odd_cnt), 32'd1);

        // 2: full decade sweep with counts cleared first
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        snap();
        for (int d = 0; d < 10; d++) begin
            hold(4'(d), 10);
            check("t2_digit_step", 32'(digit), 32'(d));
`ifdef SEG7_EN
            if (d == 8) check("t2_seg8", 32'(seg_n), 32'h00);
`endif
        end
        check("t2_no_early_roll", 32'(roll_total - roll0), 32'd0);
        hold(4'd0, 10);
        check("t2_vld_pulses", 32'(vld_total - vld0), 32'd11);
        check("t2_even_cnt", 32'(even_cnt), 32'd6);
        check("t2_odd_cnt", 32'(odd_cnt), 32'd5);
        check("t2_rollover", 32'(roll_total - roll0), 32'd1);
        check("t2_is_even", 32'(is_even), 32'd1);
        // 6: CNT_W=2 instance saw the same 5 odd and 6 even commits
        check("t6_sat_odd", 32'(s_odd_cnt), 32'd3);
        check("t6_sat_even", 32'(s_even_cnt), 32'd3);

        // 3: short glitch from 3 to 7 and back
        hold(4'd3, 10);
        check("t3_digit3", 32'(digit), 32'd3);
        snap();
        hold(4'd7, 3);
        hold(4'd3, 10);
        check("t3_no_vld", 32'(vld_total - vld0), 32'd0);
        check("t3_digit", 32'(digit), 32'd3);
        check("t3_odd_same", 32'(odd_cnt), 32'(odd0));
        check("t3_no_illegal", 32'(ill_total - ill0), 32'd0);

        // 4: illegal code, then clear the sticky flag
        snap();
        hold(4'hC, 10);
        check("t4_ill_pulses", 32'(ill_total - ill0), 32'd1);
        check("t4_err", 32'(err_sticky), 32'd1);
        check("t4_digit", 32'(digit), 32'd3);
        check("t4_no_vld", 32'(vld_total - vld0), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t4_err_clr", 32'(err_sticky), 32'd0);
        hold(4'd4, 10);
        check("t4_digit4", 32'(digit), 32'd4);

        // 5: commits held off by en, then clear coinciding with a commit
        en = 1'b0;
        snap();
        hold(4'd6, 10);
        check("t5_no_commit", 32'(vld_total - vld0), 32'd0);
        check("t5_digit_held", 32'(digit), 32'd4);
        en = 1'b1;
        @(negedge clk);
        check("t5_digit6", 32'(digit), 32'd6);
        check("t5_vld", 32'(vld_total - vld0), 32'd1);
        check("t5_even_inc", 32'(even_cnt), 32'(even0 + 1));
        en = 1'b0;
        hold(4'd7, 10);
        snap();
        en = 1'b1;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("t5_digit7", 32'(digit), 32'd7);
        check("t5_vld7", 32'(vld_total - vld0), 32'd1);
        check("t5_even_clr", 32'(even_cnt), 32'd0);
        check("t5_odd_clr", 32'(odd_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
